// File: rtl/csa_operand_sequencer_if.sv
// Handshake and operand bus between csa_operand_sequencer and its producer, adder and consumer.
interface csa_operand_sequencer_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       flush;
  logic [3:0] csa_a, csa_b, csa_c, csa_d, csa_e, csa_f;
  logic [6:0] csa_result;
  logic [6:0] out_sum;
  logic       out_valid;
  logic       out_ready;
  logic       out_err;
  logic       busy;

  modport slave (
    input  in_data, in_valid, flush, csa_result, out_ready,
    output in_ready, csa_a, csa_b, csa_c, csa_d, csa_e, csa_f,
           out_sum, out_valid, out_err, busy
  );

  modport master (
    output in_data, in_valid, flush, csa_result, out_ready,
    input  in_ready, csa_a, csa_b, csa_c, csa_d, csa_e, csa_f,
           out_sum, out_valid, out_err, busy
  );
endinterface

// File: rtl/csa_operand_sequencer.sv
// Collects six nibbles, issues them to an external six-input adder and buffers sums in order.
// Optional sum check enabled by macro CSA_OPERAND_SEQUENCER_SUM_CHECK_EN.
module csa_operand_sequencer #(
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  csa_operand_sequencer_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

  typedef enum logic [1:0] {COLLECT, WAIT, ISSUE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      idx;
  logic [3:0]      ops [6];
  logic            beat, last_beat, issue, credit, push, pop;
  logic [LATENCY:1] vld_pipe;
  logic [CW-1:0]   inflight;
  logic [6:0]      sum_mem [FIFO_DEPTH];
  logic            err_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [NW-1:0]   count;
  logic            push_err;

  assign beat      = (state == COLLECT) && bus.in_valid && !bus.flush;
  assign last_beat = beat && (idx == 3'd5);
  assign issue     = (state == ISSUE);
  assign push      = vld_pipe[LATENCY];
  assign pop       = bus.out_valid && bus.out_ready;

  always_comb begin
    inflight = '0;
    for (int k = 1; k <= LATENCY; k++) inflight = inflight + CW'(vld_pipe[k]);
  end

  // Tokens in the adder pipe already own a FIFO slot, so a push can never overflow.
  assign credit = (CW'(count) + inflight) < CW'(FIFO_DEPTH);

  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (last_beat) state_nxt = credit ? ISSUE : WAIT;
      WAIT:    if (credit)    state_nxt = ISSUE;
      ISSUE:                  state_nxt = COLLECT;
      default:                state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= COLLECT;
      idx   <= '0;
      for (int i = 0; i < 6; i++) ops[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == COLLECT) begin
        if (bus.flush) idx <= '0;
        else if (bus.in_valid) begin
          ops[idx] <= bus.in_data;
          idx      <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) vld_pipe <= '0;
    else begin
      vld_pipe[1] <= issue;
      for (int k = 2; k <= LATENCY; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

`ifdef CSA_OPERAND_SEQUENCER_SUM_CHECK_EN
  logic [6:0] op_sum;
  logic [6:0] sum_pipe [LATENCY:1];

  always_comb begin
    op_sum = '0;
    for (int i = 0; i < 6; i++) op_sum = op_sum + 7'(ops[i]);
  end

  // Reference sum rides alongside the token; only the stage qualified by vld_pipe matters.
  always_ff @(posedge clk) begin
    sum_pipe[1] <= op_sum;
    for (int k = 2; k <= LATENCY; k++) sum_pipe[k] <= sum_pipe[k-1];
  end

  assign push_err    = (bus.csa_result != sum_pipe[LATENCY]);
  assign bus.out_err = bus.out_valid && err_mem[rd_ptr];
`else
  assign push_err    = 1'b0;
  assign bus.out_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      sum_mem[wr_ptr] <= bus.csa_result;
      err_mem[wr_ptr] <= push_err;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign bus.in_ready  = (state == COLLECT);
  assign bus.out_valid = (count != '0);
  assign bus.out_sum   = sum_mem[rd_ptr];
  assign bus.busy      = (state != COLLECT) || (|vld_pipe) || (count != '0);
  assign bus.csa_a = ops[0];
  assign bus.csa_b = ops[1];
  assign bus.csa_c = ops[2];
  assign bus.csa_d = ops[3];
  assign bus.csa_e = ops[4];
  assign bus.csa_f = ops[5];
endmodule

// File: tb/tb_csa_operand_sequencer.sv
// Scoreboard bench for csa_operand_sequencer with a delayed-sum adder model.
module tb_csa_operand_sequencer;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
`ifdef CSA_OPERAND_SEQUENCER_SUM_CHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  csa_operand_sequencer_if bus ();
  csa_operand_sequencer #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int out_cnt = 0;
  bit corrupt = 1'b0;
  bit rand_rdy = 1'b0;
  logic [7:0] exp_q [$];
  int group [$];

  // Downstream adder: sum of the operands seen LAT cycles earlier.
  logic [6:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= 7'(bus.csa_a) + 7'(bus.csa_b) + 7'(bus.csa_c) +
               7'(bus.csa_d) + 7'(bus.csa_e) + 7'(bus.csa_f);
    for (int k = 1; k < LAT; k++) hist[k] <= hist[k-1];
  end
  assign bus.csa_result = corrupt ? 7'd0 : hist[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("out_sum", 32'(bus.out_sum), 32'(e[6:0]));
        chk("out_err", 32'(bus.out_err), 32'(e[7]));
      end
      out_cnt++;
    end
  end

  // One cycle of stimulus; the reference model applies the group/flush rules on acceptance.
  task automatic drive(input logic [3:0] d, input bit v, input bit fl, output bit acc);
    int s;
    bus.in_data = d; bus.in_valid = v; bus.flush = fl;
    if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    acc = 1'b0;
    if (bus.in_ready === 1'b1) begin
      if (fl) group.delete();
      else if (v) begin
        acc = 1'b1;
        group.push_back(int'(d));
        if (group.size() == 6) begin
          s = 0;
          foreach (group[i]) s += group[i];
          exp_q.push_back(corrupt ? {SC, 7'd0} : {1'b0, 7'(s)});
          group.delete();
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) drive(4'd0, 1'b0, 1'b0, a);
  endtask

  task automatic send(input logic [3:0] d, input bit fl);
    bit a;
    int n;
    n = 0;
    do begin
      drive(d, 1'b1, fl, a);
      n++;
    end while (!a && !fl && n < 300);
    if (!a && !fl) chk("send_timeout", 0, 1);
    bus.in_valid = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid !== 1'b0) && n < 500) begin
      idle(1); n++;
    end
    chk("drain_done", 32'(exp_q.size()), 0);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    exp_q.delete(); group.delete();
    repeat (cyc) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n, c0;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(2);
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_err", 32'(bus.out_err), 0);
    chk("rst_csa_a", 32'(bus.csa_a), 0);
    chk("rst_csa_f", 32'(bus.csa_f), 0);
    @(posedge clk); #1;

    // Latency: ISSUE right after last beat, out_valid LAT+1 cycles after ISSUE.
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n == 1) chk("issue_in_ready", 32'(bus.in_ready), 0);
    end while (bus.out_valid !== 1'b1 && n < 50);
    chk("out_valid_delay", 32'(n), 32'(LAT + 2));
    chk("hold_csa_a", 32'(bus.csa_a), 1);
    chk("hold_csa_c", 32'(bus.csa_c), 3);
    chk("hold_csa_f", 32'(bus.csa_f), 6);
    @(posedge clk); #1;
    drain();

    repeat (6) send(4'd15, 1'b0);
    drain();

    // Back-pressure: four groups fill the buffer, the fifth waits for credit.
    bus.out_ready = 1'b0;
    c0 = out_cnt;
    repeat (30) send(4'd1, 1'b0);
    idle(8);
    @(negedge clk);
    chk("wait_in_ready", 32'(bus.in_ready), 0);
    chk("wait_busy", 32'(bus.busy), 1);
    chk("wait_out_valid", 32'(bus.out_valid), 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1; idle(1); bus.out_ready = 1'b0;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin idle(1); n++; end
    chk("resume_in_ready", 32'(bus.in_ready), 1);
    drain();
    chk("bp_count", 32'(out_cnt - c0), 5);

    // Flush wins over a concurrent beat.
    c0 = out_cnt;
    send(4'd7, 1'b0); send(4'd8, 1'b0); send(4'd9, 1'b0);
    send(4'd5, 1'b1);
    repeat (6) send(4'd2, 1'b0);
    drain();
    idle(LAT + 4);
    chk("flush_count", 32'(out_cnt - c0), 1);

    // Reset one cycle after ISSUE discards the in-flight result.
    for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
    idle(1);
    do_reset(1);
    c0 = out_cnt;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (i == 0 || i == LAT + 3) begin
        chk("post_rst_valid", 32'(bus.out_valid), 0);
        chk("post_rst_busy", 32'(bus.busy), 0);
      end
      @(posedge clk); #1;
    end
    chk("post_rst_count", 32'(out_cnt - c0), 0);
    for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
    drain();

    // Corrupted adder output.
    corrupt = 1'b1;
    for (int i = 1; i <= 6; i++) send(4'(i), 1'b0);
    drain();
    corrupt = 1'b0;

    // Random traffic with random consumer stalls and occasional flushes.
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      bit a;
      drive(4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, a);
    end
    bus.in_valid = 1'b0; bus.flush = 1'b0;
    rand_rdy = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1);
  end
endmodule

// File: doc/csa_operand_sequencer.md
CSA_OPERAND_SEQUENCER -- requirements
Module: csa_operand_sequencer

Interface
REQ-001 Parameter: LATENCY, default 3, cycles from the issue cycle to a valid csa_result.
REQ-002 Parameter: FIFO_DEPTH, default 4, number of result-buffer entries.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  4  operand nibble.
REQ-006 in_valid  input  1  in_data is valid this cycle.
REQ-007 in_ready  output  1  the block accepts in_data this cycle.
REQ-008 flush  input  1  discard any partially collected group.
REQ-009 csa_a, csa_b, csa_c, csa_d, csa_e, csa_f  output  4 each  registered operands driven to the downstream six-input adder.
REQ-010 csa_result  input  7  adder sum, valid LATENCY cycles after issue.
REQ-011 out_sum  output  7  head-of-FIFO sum.
REQ-012 out_valid  output  1  FIFO is non-empty.
REQ-013 out_ready  input  1  consumer accepts out_sum.
REQ-014 out_err  output  1  sum-check mismatch flag for the head entry.
REQ-015 busy  output  1  high when the FSM is not in COLLECT, any result is in flight, or the FIFO is non-empty.

Function
REQ-016 FSM states SHALL be COLLECT, WAIT and ISSUE.
- COLLECT: in_ready=1.
- WAIT and ISSUE: in_ready=0.
REQ-017 In COLLECT, each in_valid&&in_ready beat SHALL load nibble index 0..5 into csa_a..csa_f respectively, and the index SHALL increment.
REQ-018 On the 6th accepted beat, the FSM SHALL go next cycle to ISSUE if credit is available, else to WAIT, and the index SHALL return to 0.
REQ-019 Credit SHALL be available when fifo_count + inflight_count < FIFO_DEPTH.
- WAIT SHALL move to ISSUE on the first cycle credit is available.
REQ-020 ISSUE SHALL last exactly one cycle, SHALL insert a token into a LATENCY-stage valid shift register, and SHALL return to COLLECT.
REQ-021 csa_a..csa_f SHALL hold their values from the 6th beat until overwritten by the next group.
REQ-022 When the token reaches stage LATENCY, the block SHALL push csa_result into the FIFO on that edge.
- Minimum issue-to-out_valid delay: LATENCY+1 cycles.
REQ-023 The FIFO SHALL pop on out_valid&&out_ready.
- Simultaneous push and pop SHALL leave the count unchanged.
- The credit rule guarantees a push never occurs when the FIFO is full.
REQ-024 When flush=1 in COLLECT, the index SHALL reset to 0 and any beat in the same cycle SHALL be dropped (flush wins).
- In WAIT or ISSUE, flush SHALL be ignored.
- Flush SHALL never affect in-flight tokens or the FIFO.
REQ-025 Throughput SHALL be one group per 7 cycles with no back-pressure.
REQ-026 Results SHALL leave in issue order, with no loss and no duplication.

Reset
REQ-027 On reset, the block SHALL enter COLLECT and clear the index, valid shift register, FIFO pointers and FIFO count.
- Reset values: csa_a..csa_f=0, out_valid=0, out_err=0, busy=0, in_ready=1 from the first cycle after reset.
REQ-028 Reset mid-group or mid-flight SHALL discard all partial, in-flight and buffered results.
- A csa_result arriving after reset SHALL be ignored.

Configuration
REQ-029 Macro CSA_OPERAND_SEQUENCER_SUM_CHECK_EN controls a sum check.
- Defined: at ISSUE, the block SHALL compute the sum of the six operands with a plain adder, carry it alongside the token, and compare it with csa_result at capture. The FIFO SHALL store a mismatch bit, presented as out_err alongside out_sum.
- Undefined: the check logic SHALL be absent and out_err SHALL be tied to 0, with the port retained.

Verification
REQ-030 Feed 1,2,3,4,5,6 with out_ready=1 -> ISSUE 1 cycle after the last beat; out_sum=21 and out_valid=1 exactly LATENCY+1 cycles after the ISSUE cycle.
REQ-031 Feed six 15s -> out_sum=90 (7'b1011010), out_err=0.
REQ-032 Hold out_ready=0 and feed 5 groups of six 1s -> 4 results buffered; the 5th group sits in WAIT with in_ready=0; one pop -> ISSUE; all 5 sums=6 drained in order.
REQ-033 Feed 3 nibbles, assert flush together with a 4th beat, then feed six 2s -> single out_sum=12, only one ISSUE.
REQ-034 Assert reset 1 cycle after ISSUE -> out_valid stays 0 and busy=0 after reset; the next group 1..6 yields 21.
REQ-035 With the macro defined, force csa_result=0 for the group 1..6 -> out_sum=0, out_err=1; without the macro, out_err stays 0.
